// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared state encoding and default constants for the PWM ramp controller
package pwm_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        RAMP_UP   = 3'd1,
        RAMP_DOWN = 3'd2,
        ESTOP     = 3'd3
    } ramp_state_e;

    localparam int IDLE_DUTY_DEFAULT = 128;
    // One ramp tick per PWM period, so this must track the PWM generator's period.
    localparam int TICK_DIV_DEFAULT  = 400000;

    function automatic ramp_state_e dir_of(input logic [7:0] duty, input logic [7:0] target);
        if (duty < target) begin
            return RAMP_UP;
        end else if (duty > target) begin
            return RAMP_DOWN;
        end
        return HOLD;
    endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// rtl/pwm_tick_div.sv - free-running divider emitting a one-cycle tick every TICK_DIV cycles
module pwm_tick_div
    import pwm_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - slew-limited duty controller with estop; PWM_RAMP_WDOG_EN adds a command watchdog
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int STEP       = 4,
    parameter int IDLE_DUTY  = IDLE_DUTY_DEFAULT,
    parameter int WDOG_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_duty,
    output logic       cmd_ready,
    input  logic       estop,
    input  logic       estop_clr,
    output logic [7:0] duty,
    output logic       busy,
    output logic       wdog_expired,
    output logic [2:0] state
);

    localparam logic [7:0] IDLE8 = 8'(IDLE_DUTY);
    localparam logic [7:0] STEP8 = 8'(STEP);
    localparam logic [8:0] STEP9 = 9'(STEP);

    ramp_state_e state_q, state_d;
    logic [7:0]  duty_q, duty_d;
    logic [7:0]  target_q, target_d;
    logic        busy_q, busy_d;
    logic        tick;
    logic        accept;
    logic        wdog_fire;
    logic [7:0]  step_val;
    logic [8:0]  up_sum;
    logic [8:0]  dn_floor;

    pwm_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign cmd_ready = (state_q != ESTOP) && !estop;
    assign accept    = cmd_valid && cmd_ready;

    // Step direction follows the registers, not the lagging state, so a
    // retarget can never make a stale direction snap past the new target.
    always_comb begin
        up_sum   = {1'b0, duty_q} + STEP9;
        dn_floor = {1'b0, target_q} + STEP9;
        step_val = duty_q;
        if (duty_q < target_q) begin
            step_val = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
        end else if (duty_q > target_q) begin
            step_val = ({1'b0, duty_q} <= dn_floor) ? target_q : duty_q - STEP8;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        busy_d   = busy_q;
        if (estop) begin
            state_d  = ESTOP;
            duty_d   = IDLE8;
            target_d = IDLE8;
            busy_d   = 1'b0;
        end else if (state_q == ESTOP) begin
            busy_d = 1'b0;
            if (estop_clr) begin
                state_d = HOLD;
            end
        end else begin
            if (tick) begin
                duty_d = step_val;
            end
            if (accept) begin
                target_d = cmd_duty;
            end else if (wdog_fire) begin
                target_d = IDLE8;
            end
            state_d = dir_of(duty_q, target_q);
            busy_d  = (duty_q != target_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= HOLD;
            duty_q   <= IDLE8;
            target_q <= IDLE8;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            busy_q   <= busy_d;
        end
    end

`ifdef PWM_RAMP_WDOG_EN
    localparam int WCW = $clog2(WDOG_TICKS + 1);
    localparam logic [WCW-1:0] WMAX = WCW'(WDOG_TICKS);

    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           wexp_q, wexp_d;

    // Counter saturates at WMAX so the watchdog fires once per silence.
    always_comb begin
        wcnt_d    = wcnt_q;
        wexp_d    = wexp_q;
        wdog_fire = 1'b0;
        if (estop || (state_q == ESTOP)) begin
            wcnt_d = '0;
        end else if (accept) begin
            wcnt_d = '0;
            wexp_d = 1'b0;
        end else if (tick && (wcnt_q != WMAX)) begin
            wcnt_d = wcnt_q + WCW'(1);
            if (wcnt_q == WMAX - WCW'(1)) begin
                wdog_fire = 1'b1;
                wexp_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            wexp_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wexp_q <= wexp_d;
        end
    end

    assign wdog_expired = wexp_q;
`else
    assign wdog_fire    = 1'b0;
    assign wdog_expired = 1'b0;
`endif

    assign duty  = duty_q;
    assign busy  = busy_q;
    assign state = state_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - table-driven and sequence checks for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;
    import pwm_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_duty;
    logic       cmd_ready;
    logic       estop;
    logic       estop_clr;
    logic [7:0] duty;
    logic       busy;
    logic       wdog_expired;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_ramp_ctrl #(
        .TICK_DIV  (4),
        .STEP      (16),
        .IDLE_DUTY (128),
        .WDOG_TICKS(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_duty    (cmd_duty),
        .cmd_ready   (cmd_ready),
        .estop       (estop),
        .estop_clr   (estop_clr),
        .duty        (duty),
        .busy        (busy),
        .wdog_expired(wdog_expired),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [7:0] cd;
        logic       es;
        logic       clr;
        logic       rdy;
        logic [7:0] duty;
        logic       busy;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int n, input logic cv, input logic [7:0] cd, input logic es,
                                input logic clr, input logic rdy, input logic [7:0] d,
                                input logic b, input logic [2:0] s);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{cv, cd, es, clr, rdy, d, b, s});
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts and ends at a negedge.
    task automatic issue_cmd(input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_duty  = d;
        @(posedge clk);
        #1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic ramp_to(input logic [7:0] tgt, input int exp_changes, input string name);
        logic [7:0] prev;
        int         changes;
        bit         mono;
        bit         done;
        bit         up;
        changes = 0;
        mono    = 1'b1;
        done    = 1'b0;
        up      = (tgt > duty);
        prev    = duty;
        issue_cmd(tgt);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (duty != prev) begin
                changes++;
                if (up ? (duty < prev) : (duty > prev)) mono = 1'b0;
                prev = duty;
            end
            if (state == HOLD && duty == tgt && !busy) begin
                done = 1'b1;
                break;
            end
        end
        @(negedge clk);
        chk({name, "_done"}, int'(done), 1);
        chk({name, "_duty"}, int'(duty), int'(tgt));
        chk({name, "_ticks"}, changes, exp_changes);
        chk({name, "_nowrap"}, int'(mono), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got %0d cycles expected fewer", 40000);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_duty  = 8'd0;
        estop     = 1'b0;
        estop_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_duty", int'(duty), 128);
        chk("reset_busy", int'(busy), 0);
        chk("reset_state", int'(state), int'(HOLD));
        chk("reset_wdog", int'(wdog_expired), 0);
        chk("reset_ready", int'(cmd_ready), 1);
        rst_n = 1'b1;

`ifdef PWM_RAMP_WDOG_EN
        begin
            bit reached;
            bit fired;
            bit settled;
            reached = 1'b0;
            fired   = 1'b0;
            settled = 1'b0;
            for (int i = 0; i < 30 && !reached; i++) begin
                issue_cmd(8'd200);
                repeat (7) begin
                    @(posedge clk);
                    #1;
                    if (duty == 8'd200) reached = 1'b1;
                end
                @(negedge clk);
            end
            chk("wdog_reach_200", int'(reached), 1);
            chk("wdog_not_early", int'(wdog_expired), 0);
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                #1;
                if (wdog_expired) begin
                    fired = 1'b1;
                    chk("wdog_fire_duty", int'(duty), 200);
                    break;
                end
            end
            @(negedge clk);
            chk("wdog_fired", int'(fired), 1);
            for (int c = 0; c < 80; c++) begin
                @(posedge clk);
                #1;
                if (duty == 8'd128 && !busy && state == HOLD) begin
                    settled = 1'b1;
                    break;
                end
            end
            @(negedge clk);
            chk("wdog_ramp_idle", int'(settled), 1);
            chk("wdog_sticky", int'(wdog_expired), 1);
            issue_cmd(8'd160);
            chk("wdog_clear", int'(wdog_expired), 0);
        end
`else
        // Ramp up to 200 with clamped last step.
        add(1, 1, 200, 0, 0, 1, 128, 0, HOLD);
        add(2, 0, 0, 0, 0, 1, 128, 1, RAMP_UP);
        add(4, 0, 0, 0, 0, 1, 144, 1, RAMP_UP);
        add(4, 0, 0, 0, 0, 1, 160, 1, RAMP_UP);
        add(4, 0, 0, 0, 0, 1, 176, 1, RAMP_UP);
        add(4, 0, 0, 0, 0, 1, 192, 1, RAMP_UP);
        add(1, 0, 0, 0, 0, 1, 200, 1, RAMP_UP);
        add(3, 0, 0, 0, 0, 1, 200, 0, HOLD);
        // Command 50 on a tick edge, then retarget 230 at duty 168.
        add(1, 1, 50, 0, 0, 1, 200, 0, HOLD);
        add(3, 0, 0, 0, 0, 1, 200, 1, RAMP_DOWN);
        add(4, 0, 0, 0, 0, 1, 184, 1, RAMP_DOWN);
        add(1, 0, 0, 0, 0, 1, 168, 1, RAMP_DOWN);
        add(1, 1, 230, 0, 0, 1, 168, 1, RAMP_DOWN);
        add(2, 0, 0, 0, 0, 1, 168, 1, RAMP_UP);
        add(4, 0, 0, 0, 0, 1, 184, 1, RAMP_UP);
        add(4, 0, 0, 0, 0, 1, 200, 1, RAMP_UP);
        add(4, 0, 0, 0, 0, 1, 216, 1, RAMP_UP);
        add(1, 0, 0, 0, 0, 1, 230, 1, RAMP_UP);
        add(4, 0, 0, 0, 0, 1, 230, 0, HOLD);
        // Estop mid-ramp with a competing command.
        add(1, 1, 0, 0, 0, 1, 230, 0, HOLD);
        add(2, 0, 0, 0, 0, 1, 230, 1, RAMP_DOWN);
        add(4, 0, 0, 0, 0, 1, 214, 1, RAMP_DOWN);
        add(1, 0, 0, 0, 0, 1, 198, 1, RAMP_DOWN);
        add(1, 1, 99, 1, 0, 0, 128, 0, ESTOP);
        add(1, 0, 0, 1, 1, 0, 128, 0, ESTOP);
        add(1, 0, 0, 0, 0, 0, 128, 0, ESTOP);
        add(1, 0, 0, 0, 1, 0, 128, 0, HOLD);
        add(4, 0, 0, 0, 0, 1, 128, 0, HOLD);

        for (int i = 0; i < vecs.size(); i++) begin
            cmd_valid = vecs[i].cv;
            cmd_duty  = vecs[i].cd;
            estop     = vecs[i].es;
            estop_clr = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_ready", i), int'(cmd_ready), int'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_duty", i), int'(duty), int'(vecs[i].duty));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("v%0d_state", i), int'(state), int'(vecs[i].st));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        estop     = 1'b0;
        estop_clr = 1'b0;

        ramp_to(8'd255, 8, "sat_255");
        ramp_to(8'd0, 16, "floor_0");

        issue_cmd(8'd255);
        repeat (10) @(negedge clk);
        chk("midramp_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_duty", int'(duty), 128);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_state", int'(state), int'(HOLD));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_discard", int'(duty), 128);
        chk("wdog_tied_low", int'(wdog_expired), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
